// File: rtl/axis_udp_frame_tx_ctrl.sv
// Control stage between the UDP beat generator and an AXI4-Stream master port.
// Buffers beats in a FWFT FIFO, builds tkeep from partial last beats and enforces an inter-frame gap.
module axis_udp_frame_tx_ctrl #(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int FIFO_DEPTH      = 8,
  parameter int IFG_CYCLES      = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [AXIS_DATA_WIDTH-1:0]           data_i,
  input  logic                                 data_valid_i,
  input  logic                                 frame_end_i,
  input  logic [$clog2(AXIS_DATA_WIDTH/8)-1:0] last_bytes_i,
  output logic                                 en_o,
  output logic                                 m_axis_tvalid,
  output logic [AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]         m_axis_tkeep,
  output logic [AXIS_DATA_WIDTH/8-1:0]         m_axis_tstrb,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic [CNT_WIDTH-1:0]                 frame_cnt_o,
  output logic                                 overflow_o
);
  localparam int KW  = AXIS_DATA_WIDTH / 8;
  localparam int LBW = $clog2(KW);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int GW  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   EN_LIMIT = (AW+1)'(FIFO_DEPTH - 2);
  localparam logic [GW-1:0] GAP_INIT = (IFG_CYCLES > 0) ? GW'(IFG_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  logic [AXIS_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [KW-1:0]              mem_keep [FIFO_DEPTH];
  logic                       mem_last [FIFO_DEPTH];

  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]    count_reg, count_next;
  logic           push, pop, fifo_empty;
  logic [KW-1:0]  keep_in;

  state_t         state_reg, state_next;
  logic [GW-1:0]  gap_reg, gap_next;
  logic           load, hs, hs_last;

  logic                       tvalid_reg, tlast_reg, en_reg, overflow_reg;
  logic [AXIS_DATA_WIDTH-1:0] tdata_reg;
  logic [KW-1:0]              tkeep_reg;
  logic [CNT_WIDTH-1:0]       frame_cnt_reg;

  // A zero byte count on the last beat means the whole beat is valid.
  genvar gi;
  generate
    for (gi = 0; gi < KW; gi++) begin : g_keep
      assign keep_in[gi] = ~frame_end_i | (last_bytes_i == '0) | (LBW'(gi) < last_bytes_i);
    end
  endgenerate

  // Fullness uses registered occupancy, so a same-cycle pop never rescues a push.
  assign push       = data_valid_i && (count_reg != DEPTH);
  assign pop        = load;
  assign fifo_empty = (count_reg == '0);
  assign count_next = count_reg + (AW+1)'(push) - (AW+1)'(pop);
  assign hs         = tvalid_reg && m_axis_tready;
  assign hs_last    = hs && tlast_reg;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr_reg] <= data_i;
      mem_keep[wr_ptr_reg] <= keep_in;
      mem_last[wr_ptr_reg] <= frame_end_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      gap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gap_reg   <= gap_next;
    end
  end

  // The last gap cycle behaves as IDLE so exactly IFG_CYCLES idle cycles separate frames.
  always_comb begin
    state_next = state_reg;
    gap_next   = gap_reg;
    case (state_reg)
      IDLE: if (!fifo_empty) state_next = SEND;
      SEND: begin
        if (hs_last) begin
          if (IFG_CYCLES == 0) begin
            state_next = fifo_empty ? IDLE : SEND;
          end else begin
            state_next = GAP;
            gap_next   = GAP_INIT;
          end
        end
      end
      GAP: begin
        if (gap_reg == '0) state_next = fifo_empty ? IDLE : SEND;
        else               gap_next   = gap_reg - GW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    case (state_reg)
      IDLE:    load = !fifo_empty;
      SEND:    load = !fifo_empty && (!tvalid_reg || (hs && (!tlast_reg || IFG_CYCLES == 0)));
      GAP:     load = !fifo_empty && (gap_reg == '0);
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tvalid_reg <= 1'b0;
      tdata_reg  <= '0;
      tkeep_reg  <= '0;
      tlast_reg  <= 1'b0;
    end else if (load) begin
      tvalid_reg <= 1'b1;
      tdata_reg  <= mem_data[rd_ptr_reg];
      tkeep_reg  <= mem_keep[rd_ptr_reg];
      tlast_reg  <= mem_last[rd_ptr_reg];
    end else if (hs) begin
      tvalid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt_reg <= '0;
      overflow_reg  <= 1'b0;
      en_reg        <= 1'b0;
    end else begin
      if (hs_last) frame_cnt_reg <= frame_cnt_reg + CNT_WIDTH'(1);
      if (data_valid_i && (count_reg == DEPTH)) overflow_reg <= 1'b1;
      en_reg <= (count_next <= EN_LIMIT);
    end
  end

  assign en_o          = en_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tkeep  = tkeep_reg;
  assign m_axis_tstrb  = tkeep_reg;
  assign m_axis_tlast  = tlast_reg;
  assign frame_cnt_o   = frame_cnt_reg;
  assign overflow_o    = overflow_reg;
endmodule

// File: tb/tb_axis_udp_frame_tx_ctrl.sv
// Bench for axis_udp_frame_tx_ctrl: two instances (IFG 4 / 32-bit count, IFG 0 / 4-bit count) share stimulus
// and are checked every cycle against a queue-based model, plus directed literal checks.
`timescale 1ns/1ps
module tb_axis_udp_frame_tx_ctrl;
  localparam int W  = 64;
  localparam int KW = 8;
  localparam int D  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i        = 1'b1;
  logic [W-1:0]  data_i       = '0;
  logic          data_valid_i = 1'b0;
  logic          frame_end_i  = 1'b0;
  logic [2:0]    last_bytes_i = '0;
  logic          tready       = 1'b0;

  logic [1:0]    en_w, tvalid_w, tlast_w, ovf_w;
  logic [W-1:0]  tdata_w [2];
  logic [KW-1:0] tkeep_w [2];
  logic [KW-1:0] tstrb_w [2];
  logic [31:0]   cnt0;
  logic [3:0]    cnt1;

  axis_udp_frame_tx_ctrl #(.AXIS_DATA_WIDTH(W), .FIFO_DEPTH(D), .IFG_CYCLES(4), .CNT_WIDTH(32)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .data_valid_i(data_valid_i),
    .frame_end_i(frame_end_i), .last_bytes_i(last_bytes_i), .en_o(en_w[0]),
    .m_axis_tvalid(tvalid_w[0]), .m_axis_tdata(tdata_w[0]), .m_axis_tkeep(tkeep_w[0]),
    .m_axis_tstrb(tstrb_w[0]), .m_axis_tlast(tlast_w[0]), .m_axis_tready(tready),
    .frame_cnt_o(cnt0), .overflow_o(ovf_w[0]));

  axis_udp_frame_tx_ctrl #(.AXIS_DATA_WIDTH(W), .FIFO_DEPTH(D), .IFG_CYCLES(0), .CNT_WIDTH(4)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .data_valid_i(data_valid_i),
    .frame_end_i(frame_end_i), .last_bytes_i(last_bytes_i), .en_o(en_w[1]),
    .m_axis_tvalid(tvalid_w[1]), .m_axis_tdata(tdata_w[1]), .m_axis_tkeep(tkeep_w[1]),
    .m_axis_tstrb(tstrb_w[1]), .m_axis_tlast(tlast_w[1]), .m_axis_tready(tready),
    .frame_cnt_o(cnt1), .overflow_o(ovf_w[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [W-1:0]  d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  beat_t       mq [2][$];
  beat_t       m_out [2];
  bit          m_tv [2];
  int          m_cool [2];
  int unsigned m_cnt [2];
  bit          m_ovf [2];
  bit          m_en [2];
  bit          started = 1'b0;
  int          m_occ;
  bit          m_hs, m_can;

  function automatic int ifg_of(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  function automatic logic [31:0] cnt_mask(input int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction

  function automatic logic [31:0] get_cnt(input int k);
    return (k == 0) ? cnt0 : {28'd0, cnt1};
  endfunction

  function automatic beat_t mk_beat(input logic [W-1:0] d, input logic fe, input logic [2:0] lb);
    beat_t b;
    b.d = d;
    b.l = fe;
    b.k = (fe && lb != 3'd0) ? (8'hFF >> (8 - int'(lb))) : 8'hFF;
    return b;
  endfunction

  // cooldown = idle cycles still owed after a tlast handshake; the head may load on the edge it reaches 0
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_i) begin
        mq[k].delete();
        m_tv[k] = 1'b0; m_out[k] = '0; m_cool[k] = 0;
        m_cnt[k] = 0; m_ovf[k] = 1'b0; m_en[k] = 1'b0;
        started = 1'b1;
      end else begin
        m_occ = mq[k].size();
        m_hs  = m_tv[k] && tready;
        m_can = 1'b1;
        if (m_cool[k] > 0) begin
          m_cool[k]--;
          m_can = (m_cool[k] == 0);
        end
        if (m_hs && m_out[k].l) begin
          m_cnt[k]++;
          if (k == 0) $display("frame %0d delivered (ifg4 instance) at %0t", m_cnt[k], $time);
          m_cool[k] = ifg_of(k);
          if (m_cool[k] > 0) m_can = 1'b0;
        end
        if (m_can && (!m_tv[k] || m_hs) && m_occ > 0) begin
          m_out[k] = mq[k].pop_front();
          m_tv[k]  = 1'b1;
        end else if (m_hs) begin
          m_tv[k] = 1'b0;
        end
        if (data_valid_i) begin
          if (m_occ < D) mq[k].push_back(mk_beat(data_i, frame_end_i, last_bytes_i));
          else           m_ovf[k] = 1'b1;
        end
        m_en[k] = (mq[k].size() <= D - 2);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("en_o[%0d]", k), 64'(en_w[k]), 64'(m_en[k]));
        chk($sformatf("tvalid[%0d]", k), 64'(tvalid_w[k]), 64'(m_tv[k]));
        chk($sformatf("frame_cnt[%0d]", k), 64'(get_cnt(k)), 64'(m_cnt[k] & cnt_mask(k)));
        chk($sformatf("overflow[%0d]", k), 64'(ovf_w[k]), 64'(m_ovf[k]));
        if (m_tv[k]) begin
          chk($sformatf("tdata[%0d]", k), tdata_w[k], m_out[k].d);
          chk($sformatf("tkeep[%0d]", k), 64'(tkeep_w[k]), 64'(m_out[k].k));
          chk($sformatf("tstrb[%0d]", k), 64'(tstrb_w[k]), 64'(m_out[k].k));
          chk($sformatf("tlast[%0d]", k), 64'(tlast_w[k]), 64'(m_out[k].l));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic fe, input logic [2:0] lb);
    data_valid_i = v;
    data_i       = d;
    frame_end_i  = fe;
    last_bytes_i = lb;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(1'b0, '0, 1'b0, 3'd0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (n < limit && !(mq[0].size() == 0 && mq[1].size() == 0 && !m_tv[0] && !m_tv[1] &&
                          m_cool[0] == 0 && m_cool[1] == 0)) begin
      tick();
      n++;
    end
    if (n >= limit) chk("drain_timeout", 64'(n), 64'(0));
    tick();
    tick();
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_en[%0d]", tag, k), 64'(en_w[k]), 64'd0);
      chk($sformatf("%s_tvalid[%0d]", tag, k), 64'(tvalid_w[k]), 64'd0);
      chk($sformatf("%s_tdata[%0d]", tag, k), tdata_w[k], 64'd0);
      chk($sformatf("%s_tkeep[%0d]", tag, k), 64'(tkeep_w[k]), 64'd0);
      chk($sformatf("%s_tstrb[%0d]", tag, k), 64'(tstrb_w[k]), 64'd0);
      chk($sformatf("%s_tlast[%0d]", tag, k), 64'(tlast_w[k]), 64'd0);
      chk($sformatf("%s_ovf[%0d]", tag, k), 64'(ovf_w[k]), 64'd0);
      chk($sformatf("%s_cnt[%0d]", tag, k), 64'(get_cnt(k)), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  logic [W-1:0] bd [16];
  int gap_len [2];
  bit in_gap [2];
  bit gap_done [2];
  int bi, fi, flen, cyc, hs_n;
  bit found;

  initial begin
    for (int i = 0; i < 16; i++) bd[i] = {$urandom, $urandom};

    // reset state
    tick();
    tick();
    chk_zero("reset");
    rst_i = 1'b0;
    tick();
    chk("en_after_reset", 64'(en_w[0]), 64'd1);

    // 3-beat frame, last beat 3 bytes
    tready = 1'b1;
    drive(1'b1, bd[0], 1'b0, 3'd0); tick();
    chk("latency_not_early", 64'(tvalid_w[0]), 64'd0);
    drive(1'b1, bd[1], 1'b0, 3'd0); tick();
    chk("latency_first_valid", 64'(tvalid_w[0]), 64'd1);
    chk("first_beat_data", tdata_w[0], bd[0]);
    drive(1'b1, bd[2], 1'b1, 3'd3); tick();
    chk("second_beat_data", tdata_w[0], bd[1]);
    drive(1'b0, '0, 1'b0, 3'd0); tick();
    chk("third_beat_data", tdata_w[0], bd[2]);
    chk("last_tkeep", 64'(tkeep_w[0]), 64'h07);
    chk("last_tlast", 64'(tlast_w[0]), 64'd1);
    chk("cnt_before_last", 64'(cnt0), 64'd0);
    tick();
    chk("cnt_after_frame", 64'(cnt0), 64'd1);
    wait_idle(100);

    // two queued 3-beat frames: idle gap between them
    for (int k = 0; k < 2; k++) begin gap_len[k] = 0; in_gap[k] = 1'b0; gap_done[k] = 1'b0; end
    for (int c = 0; c < 40; c++) begin
      if (c < 6) drive(1'b1, bd[c + 3], (c == 2) || (c == 5), 3'd0);
      else       drive(1'b0, '0, 1'b0, 3'd0);
      tick();
      for (int k = 0; k < 2; k++) begin
        if (in_gap[k] && !gap_done[k]) begin
          if (tvalid_w[k]) gap_done[k] = 1'b1;
          else             gap_len[k]++;
        end
        if (!in_gap[k] && tvalid_w[k] && tlast_w[k]) in_gap[k] = 1'b1;
      end
    end
    chk("gap_seen_ifg4", 64'(gap_done[0]), 64'd1);
    chk("gap_len_ifg4", 64'(gap_len[0]), 64'd4);
    chk("gap_seen_ifg0", 64'(gap_done[1]), 64'd1);
    chk("gap_len_ifg0", 64'(gap_len[1]), 64'd0);
    wait_idle(100);

    // stall: tready low for 20 cycles, generator obeys en_o
    tready = 1'b0;
    bi = 0;
    for (int c = 0; c < 20; c++) begin
      if (en_w[0] && en_w[1] && bi < 8) begin
        drive(1'b1, bd[bi], (bi % 4) == 3, 3'd0);
        bi++;
      end else begin
        drive(1'b0, '0, 1'b0, 3'd0);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 3'd0);
    chk("stall_beats_accepted", 64'(bi), 64'd8);
    chk("stall_en0_low", 64'(en_w[0]), 64'd0);
    chk("stall_en1_low", 64'(en_w[1]), 64'd0);
    chk("stall_no_overflow", 64'(ovf_w[0]), 64'd0);
    chk("stall_tdata_held", tdata_w[0], bd[0]);
    tready = 1'b1;
    wait_idle(100);

    // forced overflow: 10 beats into 1 output slot + 8 FIFO entries
    tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, bd[i + 4], i == 8, 3'd5);
      tick();
    end
    drive(1'b0, '0, 1'b0, 3'd0);
    chk("overflow_set0", 64'(ovf_w[0]), 64'd1);
    chk("overflow_set1", 64'(ovf_w[1]), 64'd1);
    tready = 1'b1;
    hs_n = 0;
    for (int c = 0; c < 30; c++) begin
      if (tvalid_w[0] && tready) hs_n++;
      tick();
    end
    chk("overflow_beats_out", 64'(hs_n), 64'd9);
    chk("overflow_sticky", 64'(ovf_w[0]), 64'd1);
    wait_idle(100);

    // 100 random frames, random tready
    do_reset();
    fi = 0; bi = 0; cyc = 0;
    flen = $urandom_range(1, 16);
    while (fi < 100 && cyc < 20000) begin
      tready = 1'($urandom_range(0, 1));
      if (en_w[0] && en_w[1] && $urandom_range(0, 3) != 0) begin
        drive(1'b1, {$urandom, $urandom}, bi == flen - 1, 3'($urandom_range(0, 7)));
        bi++;
        if (bi == flen) begin
          bi = 0;
          fi++;
          flen = $urandom_range(1, 16);
        end
      end else begin
        drive(1'b0, '0, 1'b0, 3'd0);
      end
      tick();
      cyc++;
    end
    drive(1'b0, '0, 1'b0, 3'd0);
    chk("random_frames_sent", 64'(fi), 64'd100);
    tready = 1'b1;
    wait_idle(2000);
    chk("random_cnt0", 64'(cnt0), 64'd100);
    chk("random_cnt1_wrapped", 64'(cnt1), 64'd4);
    chk("random_no_overflow", 64'(ovf_w[0]), 64'd0);

    // reset during beat 2 of a 5-beat frame
    do_reset();
    tready = 1'b1;
    bi = 0; found = 1'b0;
    for (int c = 0; c < 16 && !found; c++) begin
      if (bi < 5) begin
        drive(1'b1, bd[bi + 8], bi == 4, 3'd0);
        bi++;
      end else begin
        drive(1'b0, '0, 1'b0, 3'd0);
      end
      tick();
      if (tvalid_w[0] && tdata_w[0] == bd[9]) found = 1'b1;
    end
    chk("midreset_reached_beat2", 64'(found), 64'd1);
    rst_i = 1'b1;
    drive(1'b0, '0, 1'b0, 3'd0);
    tick();
    chk_zero("midreset");
    rst_i = 1'b0;
    tick();
    drive(1'b1, bd[14], 1'b0, 3'd0); tick();
    drive(1'b1, bd[15], 1'b1, 3'd2); tick();
    drive(1'b0, '0, 1'b0, 3'd0);
    chk("midreset_cnt_restart", 64'(cnt0), 64'd0);
    chk("midreset_new_first", tdata_w[0], bd[14]);
    wait_idle(100);
    chk("midreset_cnt0_after", 64'(cnt0), 64'd1);
    chk("midreset_cnt1_after", 64'(cnt1), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
